// File: rtl/acc_noc_pkg.sv
// Shared types and header helpers for the accelerator NoC output packetizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_noc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_e;

    localparam int unsigned LEN_W        = 4;
    localparam int unsigned HDR_DEST_LSB = 0;

    // Source ID sits directly above the {y,x} destination pair.
    function automatic int unsigned hdr_src_lsb(input int unsigned xy_sz);
        return 2 * xy_sz;
    endfunction

    // Length sits directly above the source ID.
    function automatic int unsigned hdr_len_lsb(input int unsigned xy_sz);
        return 4 * xy_sz;
    endfunction

    // Build the single header word; every bit above the length field stays 0.
    function automatic logic [31:0] make_header(
        input logic [31:0]      x,
        input logic [31:0]      y,
        input logic [31:0]      src,
        input logic [LEN_W-1:0] len,
        input int unsigned      xy_sz = 4
    );
        logic [31:0] hdr;
        hdr = (x << HDR_DEST_LSB)
            | (y << (HDR_DEST_LSB + xy_sz))
            | (src << hdr_src_lsb(xy_sz))
            | (32'(len) << hdr_len_lsb(xy_sz));
        return hdr;
    endfunction

endpackage

// File: rtl/acc_noc_packet_out_fifo.sv
// Single-clock payload FIFO with occupancy count, full and empty flags.
// Latency: a pushed word is at the head on the cycle after the push.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module acc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers, count and storage; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset flushes by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only read when count says valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/acc_noc_packet_out.sv
// Packetizer: header word {len, src, y, x} followed by len payload words on AXI-Stream.
// Latency: header one cycle after command accept; payload back-to-back when FIFO holds data.
// Backpressure: output register holds while TREADY low; pay_ready drops when FIFO full.
module acc_noc_packet_out
    import acc_noc_pkg::*;
#(
    parameter int XY_SZ      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_high,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [XY_SZ-1:0]     cmd_x_dest,
    input  logic [XY_SZ-1:0]     cmd_y_dest,
    input  logic [3:0]           cmd_len,
    input  logic                 pay_valid,
    output logic                 pay_ready,
    input  logic [31:0]          pay_data,
    input  logic                 stream_out_TREADY,
    output logic                 stream_out_TVALID,
    output logic [31:0]          stream_out_TDATA,
    output logic [3:0]           stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    output logic                 pkt_sent
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic        live_q, live_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  ld_rem_q, ld_rem_d;

    logic [31:0]      fifo_dat;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fire;
    logic             out_free;
    logic             accept;

    // live_q keeps ready outputs low while reset is held and for the edge it releases on.
    assign cmd_ready         = live_q && (state_q == IDLE);
    assign accept            = cmd_valid && cmd_ready;
    assign pay_ready         = live_q && !fifo_full;
    assign fifo_push         = pay_valid && pay_ready;
    assign fire              = tvalid_q && stream_out_TREADY;
    assign out_free          = !tvalid_q || stream_out_TREADY;
    assign stream_out_TVALID = tvalid_q;
    assign stream_out_TDATA  = tdata_q;
    assign stream_out_TLAST  = tlast_q;
    assign stream_out_TKEEP  = {4{tvalid_q}};
    assign pkt_sent          = fire && tlast_q;

    acc_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_line),
        .rst      (clk_line_rst_high),
        .push     (fifo_push),
        .push_dat (pay_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // FSM and output register next-state. ld_rem counts words still to be
    // pulled from the FIFO, rem counts beats still to handshake; they differ
    // by the word sitting in the output register.
    always_comb begin
        state_d  = state_q;
        live_d   = 1'b1;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        len_d    = len_q;
        rem_d    = rem_q;
        ld_rem_d = ld_rem_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tdata_d  = make_header(32'(cmd_x_dest), 32'(cmd_y_dest),
                                           32'(HsrcId), cmd_len, XY_SZ);
                    tvalid_d = 1'b1;
                    tlast_d  = (cmd_len == 4'd0);
                    len_d    = cmd_len;
                    state_d  = HEADER;
                end
            end
            HEADER: begin
                if (fire) begin
                    if (len_q == 4'd0) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        rem_d   = len_q;
                        state_d = DATA;
                        if (!fifo_empty) begin
                            tdata_d  = fifo_dat;
                            tvalid_d = 1'b1;
                            tlast_d  = (len_q == 4'd1);
                            fifo_pop = 1'b1;
                            ld_rem_d = len_q - 4'd1;
                        end else begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            ld_rem_d = len_q;
                        end
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    rem_d = rem_q - 4'd1;
                end
                if (fire && (rem_q == 4'd1)) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = IDLE;
                end else if (out_free) begin
                    if ((ld_rem_q != 4'd0) && !fifo_empty) begin
                        tdata_d  = fifo_dat;
                        tvalid_d = 1'b1;
                        tlast_d  = (ld_rem_q == 4'd1);
                        fifo_pop = 1'b1;
                        ld_rem_d = ld_rem_q - 4'd1;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    // Register state and outputs; reset truncates any packet in flight.
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            len_q    <= '0;
            rem_q    <= '0;
            ld_rem_q <= '0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            ld_rem_q <= ld_rem_d;
        end
    end

endmodule

// File: tb/tb_acc_noc_packet_out.sv
// Bench for acc_noc_packet_out: packet-level scoreboard plus directed scenarios.
// Latency: n/a.
// Backpressure: drives TREADY patterns including per-cycle toggling.
module tb_acc_noc_packet_out;

    logic        clk_line = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  HsrcId = 8'h21;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_x_dest = '0;
    logic [3:0]  cmd_y_dest = '0;
    logic [3:0]  cmd_len = '0;
    logic        pay_valid = 1'b0;
    logic        pay_ready;
    logic [31:0] pay_data = '0;
    logic        tready = 1'b0;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        pkt_sent;

    acc_noc_packet_out #(.XY_SZ(4), .FIFO_DEPTH(8)) dut (
        .clk_line          (clk_line),
        .clk_line_rst_high (rst),
        .HsrcId            (HsrcId),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_x_dest        (cmd_x_dest),
        .cmd_y_dest        (cmd_y_dest),
        .cmd_len           (cmd_len),
        .pay_valid         (pay_valid),
        .pay_ready         (pay_ready),
        .pay_data          (pay_data),
        .stream_out_TREADY (tready),
        .stream_out_TVALID (tvalid),
        .stream_out_TDATA  (tdata),
        .stream_out_TKEEP  (tkeep),
        .stream_out_TLAST  (tlast),
        .pkt_sent          (pkt_sent)
    );

    always #5 clk_line = ~clk_line;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Packet-level model: pending headers, payload words in push order,
    // and beats left in the packet currently on the wire.
    logic [31:0] exp_hdr[$];
    int          exp_len[$];
    logic [31:0] paq[$];
    int          cur_left = 0;

    // Log of handshaked beats for the directed literal checks.
    logic [31:0] log_dat[$];
    logic        log_last[$];
    int          log_cyc[$];
    int          psent_cnt = 0;
    int          stall_cnt = 0;
    int          bubble_cnt = 0;

    int          cyc = 0;
    logic        rst_at_edge = 1'b1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(posedge clk_line) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Compare process: every cycle, away from the active edge.
    logic        m_fire;
    int          m_occ;
    logic        m_in_pkt;
    logic [31:0] m_exp;
    always @(negedge clk_line) begin
        if (rst_at_edge) begin
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_tkeep", tkeep, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_pkt_sent", pkt_sent, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_pay_ready", pay_ready, 0);
            exp_hdr.delete();
            exp_len.delete();
            paq.delete();
            cur_left   = 0;
            prev_stall = 1'b0;
        end else begin
            m_in_pkt = (exp_hdr.size() != 0) || (cur_left != 0);
            m_occ    = paq.size() - ((tvalid && cur_left > 0) ? 1 : 0);
            m_fire   = tvalid && tready;
            chk("cmd_ready", cmd_ready, !m_in_pkt);
            chk("pay_ready", pay_ready, m_occ < 8);
            chk("tkeep", tkeep, tvalid ? 4'hF : 4'h0);
            chk("pkt_sent", pkt_sent, m_fire && tlast);
            if (prev_stall) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, prev_data);
                chk("stall_tlast", tlast, prev_last);
            end
            if (!tvalid && cur_left > 0) bubble_cnt++;
            if (m_fire) begin
                if (cur_left == 0) begin
                    if (exp_hdr.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        chk("hdr_tdata", tdata, exp_hdr[0]);
                        chk("hdr_tlast", tlast, exp_len[0] == 0);
                        cur_left = exp_len[0];
                        void'(exp_hdr.pop_front());
                        void'(exp_len.pop_front());
                    end
                end else begin
                    if (paq.size() == 0) begin
                        chk("data_without_payload", 1, 0);
                    end else begin
                        m_exp = paq.pop_front();
                        chk("data_tdata", tdata, m_exp);
                    end
                    chk("data_tlast", tlast, cur_left == 1);
                    cur_left--;
                end
                log_dat.push_back(tdata);
                log_last.push_back(tlast);
                log_cyc.push_back(cyc);
            end
            if (pkt_sent) psent_cnt++;
            if (tvalid && !tready) stall_cnt++;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (cmd_valid && cmd_ready) begin
                exp_hdr.push_back({12'h000, cmd_len, HsrcId, cmd_y_dest, cmd_x_dest});
                exp_len.push_back(int'(cmd_len));
            end
            if (pay_valid && pay_ready) paq.push_back(pay_data);
        end
    end

    task automatic tick();
        @(posedge clk_line);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        logic ok;
        ok        = 1'b0;
        pay_valid = 1'b1;
        pay_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_line);
            if (pay_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        pay_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic send_cmd(input logic [3:0] x, input logic [3:0] y,
                            input logic [3:0] len, output int acc_cyc);
        logic ok;
        ok         = 1'b0;
        acc_cyc    = -1;
        cmd_valid  = 1'b1;
        cmd_x_dest = x;
        cmd_y_dest = y;
        cmd_len    = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_line);
            if (cmd_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        tick();
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_timeout", 0, 1);
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_line);
            if (exp_hdr.size() == 0 && cur_left == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        if (!ok) chk("packet_timeout", 0, 1);
    endtask

    task automatic clear_log();
        log_dat.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int n;
    int ps0;
    logic [31:0] exp_w [$];
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Preloaded len=2 packet, TREADY high.
        tready = 1'b1;
        push_word(32'hA);
        push_word(32'hB);
        clear_log();
        ps0 = psent_cnt;
        send_cmd(4'd3, 4'd5, 4'd2, n);
        wait_done();
        exp_w = '{32'h0002_2153, 32'hA, 32'hB};
        chk("t1_beats", log_dat.size(), 3);
        for (int i = 0; i < 3 && i < log_dat.size(); i++) begin
            chk("t1_data", log_dat[i], exp_w[i]);
            chk("t1_last", log_last[i], i == 2);
            chk("t1_cycle", log_cyc[i], n + 1 + i);
        end
        chk("t1_pkt_sent", psent_cnt - ps0, 1);

        // len=0 header-only packet; the preloaded word must stay in the FIFO.
        push_word(32'h55);
        clear_log();
        send_cmd(4'd1, 4'd1, 4'd0, n);
        wait_done();
        chk("t2_beats", log_dat.size(), 1);
        if (log_dat.size() > 0) begin
            chk("t2_data", log_dat[0], 32'h0000_2111);
            chk("t2_last", log_last[0], 1);
        end
        chk("t2_fifo_kept", paq.size(), 1);

        // len=3 with TREADY toggling every cycle.
        clear_log();
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    tready = ~tready;
                    tick();
                end
            end
            begin
                push_word(32'h31);
                push_word(32'h32);
                send_cmd(4'd2, 4'd6, 4'd3, n);
            end
        join
        tready = 1'b1;
        wait_done();
        exp_w = '{32'h0003_2162, 32'h55, 32'h31, 32'h32};
        chk("t3_beats", log_dat.size(), 4);
        for (int i = 0; i < 4 && i < log_dat.size(); i++) begin
            chk("t3_data", log_dat[i], exp_w[i]);
            chk("t3_last", log_last[i], i == 3);
        end
        chk("t3_stalls_seen", stall_cnt > 0, 1);

        // len=4 with payload trickling in one word every 3 cycles.
        clear_log();
        bubble_cnt = 0;
        fork
            send_cmd(4'd4, 4'd2, 4'd4, n);
            begin
                for (int i = 0; i < 4; i++) begin
                    push_word(32'h40 + i);
                    tick();
                    tick();
                end
            end
        join
        wait_done();
        exp_w = '{32'h0004_2124, 32'h40, 32'h41, 32'h42, 32'h43};
        chk("t4_beats", log_dat.size(), 5);
        for (int i = 0; i < 5 && i < log_dat.size(); i++) begin
            chk("t4_data", log_dat[i], exp_w[i]);
            chk("t4_last", log_last[i], i == 4);
        end
        chk("t4_bubbles_seen", bubble_cnt > 0, 1);

        // Fill the FIFO with 9 attempts; 9th is dropped.
        for (int i = 0; i < 9; i++) begin
            pay_valid = 1'b1;
            pay_data  = 32'h100 + i;
            tick();
        end
        pay_valid = 1'b0;
        @(negedge clk_line);
        chk("t5_pay_ready_full", pay_ready, 0);
        chk("t5_model_occ", paq.size(), 8);
        tick();
        clear_log();
        send_cmd(4'd7, 4'd7, 4'd8, n);
        wait_done();
        chk("t5_beats", log_dat.size(), 9);
        if (log_dat.size() > 0) chk("t5_hdr", log_dat[0], 32'h0008_2177);
        for (int i = 1; i < 9 && i < log_dat.size(); i++) begin
            chk("t5_data", log_dat[i], 32'h100 + i - 1);
            chk("t5_last", log_last[i], i == 8);
        end

        // Reset in the middle of a len=3 packet, then a clean len=1 packet.
        tready = 1'b0;
        push_word(32'h60);
        push_word(32'h61);
        push_word(32'h62);
        clear_log();
        send_cmd(4'd1, 4'd2, 4'd3, n);
        tready = 1'b1;
        tick();
        tick();
        tready = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("t6_beats_before_rst", log_dat.size(), 2);
        if (log_dat.size() == 2) begin
            chk("t6_hdr", log_dat[0], 32'h0003_2121);
            chk("t6_word", log_dat[1], 32'h60);
            chk("t6_no_last", log_last[1], 0);
        end
        tick();
        tick();
        tready = 1'b1;
        clear_log();
        push_word(32'h70);
        send_cmd(4'd5, 4'd4, 4'd1, n);
        wait_done();
        exp_w = '{32'h0001_2145, 32'h70};
        chk("t6_post_beats", log_dat.size(), 2);
        for (int i = 0; i < 2 && i < log_dat.size(); i++) begin
            chk("t6_post_data", log_dat[i], exp_w[i]);
            chk("t6_post_last", log_last[i], i == 1);
        end

        repeat (3) tick();
        chk("end_model_empty", paq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_noc_packet_out.md
# acc_noc_packet_out

Output-side NoC packetizer for accelerator tiles, the stage downstream of the accelerator logic and the counterpart of the input-side NoC buffer. The accelerator issues a send command (destination X/Y plus payload length) and pushes payload words. The block builds a one-word header carrying destination, source tile ID and length, then drives the header and payload onto the tile's AXI-Stream output port, asserting TLAST on the final beat. Payload is buffered in an internal FIFO so the accelerator can pre-load data before the command or while a packet is in flight.

## Interface
- XY_SZ, 4, width of one X or Y coordinate; legal range 1..7
- FIFO_DEPTH, 8, payload FIFO depth in 32-bit words; must be a power of two, at least 2
- clk_line  in  1  line clock; the block's only clock
- clk_line_rst_high  in  1  reset, synchronous, active-high
- HsrcId  in  2*XY_SZ  this tile's ID {y,x}; sampled at command accept
- cmd_valid  in  1  send command valid
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_x_dest  in  XY_SZ  destination X
- cmd_y_dest  in  XY_SZ  destination Y
- cmd_len  in  4  payload word count, 0..15
- pay_valid  in  1  payload word valid
- pay_ready  out  1  FIFO not full
- pay_data  in  32  payload word
- stream_out_TREADY  in  1  downstream ready
- stream_out_TVALID  out  1  beat valid
- stream_out_TDATA  out  32  header or payload
- stream_out_TKEEP  out  4  always 4'hF while TVALID is high, otherwise 0
- stream_out_TLAST  out  1  final beat of a packet
- pkt_sent  out  1  one-cycle pulse on the cycle the TLAST beat handshakes

## Operation
- Header layout:
  - [2*XY_SZ-1:0] = {y_dest, x_dest}
  - [4*XY_SZ-1:2*XY_SZ] = HsrcId
  - [4*XY_SZ+3:4*XY_SZ] = len
  - all remaining bits are 0
- FSM states: IDLE, HEADER, DATA.
  - IDLE: cmd_ready=1. On cmd_valid, latch dest/src/len, load the header into the output register and go to HEADER.
  - HEADER: hold the header beat until TREADY. On handshake, go to IDLE if len==0, otherwise go to DATA with remaining=len.
  - DATA: load the FIFO head into the output register when the FIFO is non-empty and the register is free. Decrement remaining on each handshake. On the handshake with remaining==1, go to IDLE.
- len==0: the header beat is the packet's only beat and carries TLAST=1.
- Output register loads when (!TVALID || TREADY). TDATA, TLAST and TKEEP stay stable while TVALID=1 and TREADY=0.
- An empty FIFO in DATA produces bubbles (TVALID=0). This is legal; the packet is never aborted.
- pay_ready = !full, computed from the registered count.
  - A push while full is ignored.
  - Simultaneous push and pop when not full leaves the count unchanged.
- Payload words are consumed strictly in FIFO order. Words pushed before a command belong to the next packet(s).
- Reset: every output is 0 (cmd_ready becomes 1 the first cycle after reset releases). The FIFO is flushed and the FSM returns to IDLE.
- Reset mid-packet truncates the packet without TLAST. Recovery is the router's responsibility.

## Timing
- Command accepted at cycle N: header TVALID=1 at N+1.
- With TREADY held high and the FIFO pre-loaded:
  - header at N+1, payload word k at N+1+k
  - one beat per cycle, no bubble between header and data
  - next cmd_ready=1 on the cycle after the TLAST handshake
- Word pushed into an empty FIFO at cycle M is visible on TDATA no earlier than M+1.
- pkt_sent is asserted in the same cycle as the TLAST handshake.

## Structure
- Package acc_noc_pkg holds:
  - the state typedef (IDLE/HEADER/DATA)
  - header field offset constants
  - the function make_header(x, y, src, len)
- Sub-module acc_sync_fifo: single-clock, parameterized width/depth FIFO with count, full and empty, and synchronous active-high reset.

## Test plan
- HsrcId=8'h21, cmd x=3, y=5, len=2, FIFO pre-loaded with 32'hA, 32'hB, TREADY=1 -> beats 32'h0002_2153, 32'hA, 32'hB. TLAST only on 32'hB; pkt_sent for one cycle; cmd_ready=1 on the cycle after that handshake.
- len=0, x=1, y=1 -> single header beat 32'h0000_2111 with TLAST=1; no FIFO pop.
- len=3 with TREADY toggling 1/0 every cycle -> TDATA/TLAST stable during every stall, 4 beats total, order preserved.
- Command len=4, payload pushed one word every 3 cycles -> bubbles on TVALID, exactly 4 data beats, TLAST on the 4th.
- Push 9 words into an empty FIFO with no command -> pay_ready=0 after the 8th, 9th word dropped. Then cmd len=8 -> the first 8 words are emitted.
- Assert reset during DATA after 1 of 3 payload beats -> next cycle all outputs are 0 and the FIFO is empty; a subsequent len=1 packet is correct.
